// File: rtl/oifs_tx_stream.sv
// -----------------------------------------------------------------------------
// oifs_tx_stream
// FTDI opto-isolated fast-serial (OIFS) transmitter with an input FIFO.
//
// Each frame carries one {channel,data} word:
//   start bit 0, D0..D(DATA_W-1) LSB first, channel bit.
// FSCLK is divided down from i_clk and runs only while a frame is on the wire.
// A new frame starts only when the synchronised FSCTS is high. After every
// frame there is a hold-off, so a late FSCTS deassert from the device is seen
// before the next frame starts.
//
// Ports
//   i_clk      system clock
//   i_arst     synchronous active-high reset
//   i_valid    source word valid; a word is taken when i_valid & o_ready
//   i_data     source payload (DATA_W bits)
//   i_channel  channel bit, 0=A 1=B
//   o_ready    FIFO not full (registered)
//   o_level    FIFO occupancy, 0..FIFO_DEPTH
//   o_busy     frame in progress or in hold-off
//   o_done     one-cycle pulse once the last frame bit has been sent
//   i_fscts    device clear-to-send (asynchronous)
//   o_fsclk    serial clock to the device, idles high
//   o_fsdi     serial data to the device, idles high
// -----------------------------------------------------------------------------
module oifs_tx_stream #(
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int CTS_HOLDOFF = 4
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_channel,
    output logic                          o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_done,
    input  logic                          i_fscts,
    output logic                          o_fsclk,
    output logic                          o_fsdi
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = AW + 1;
    localparam int FRAME_W = DATA_W + 2;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int HOLD_W  = $clog2(CTS_HOLDOFF + 1);

    localparam logic [AW-1:0]     PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO  = LVL_W'(0);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CTS_HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               state_r, state_nxt;
    logic [DATA_W:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]     level_r, level_nxt;
    logic                 ready_r;
    logic                 cts_meta_r, cts_sync_r;
    logic [FRAME_W-1:0]   shift_r;
    logic [DIV_W-1:0]     div_r;
    logic [BIT_W-1:0]     bit_r;
    logic [HOLD_W-1:0]    hold_r;
    logic                 fsclk_r, fsdi_r, busy_r, done_r;
    logic                 wr_s, pop_s;
    logic                 fsclk_s, fsdi_s, busy_s, done_s;
    logic [DATA_W:0]      head_s;

    // o_ready is a registered copy of "not full", so a write always has room.
    assign wr_s    = i_valid & ready_r;
    assign head_s  = mem_r[rd_ptr_r];

    assign o_ready = ready_r;
    assign o_level = level_r;
    assign o_busy  = busy_r;
    assign o_done  = done_r;
    assign o_fsclk = fsclk_r;
    assign o_fsdi  = fsdi_r;

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge i_clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {i_channel, i_data};
        end
    end

    // Next FIFO occupancy from this cycle's write and pop.
    always_comb begin
        level_nxt = level_r;
        case ({wr_s, pop_s})
            2'b10:   level_nxt = level_r + LVL_ONE;
            2'b01:   level_nxt = level_r - LVL_ONE;
            default: level_nxt = level_r;
        endcase
    end

    // FIFO pointers, level and ready flag.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
            ready_r  <= 1'b1;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_nxt;
            ready_r <= (level_nxt != LVL_FULL);
        end
    end

    // Two-flop synchroniser for the asynchronous FSCTS input.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            cts_meta_r <= 1'b0;
            cts_sync_r <= 1'b0;
        end else begin
            cts_meta_r <= i_fscts;
            cts_sync_r <= cts_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next state plus the pin values for this state; the pins are registered
    // below, so they lag the state by one cycle.
    always_comb begin
        state_nxt = state_r;
        pop_s     = 1'b0;
        fsclk_s   = 1'b1;
        fsdi_s    = 1'b1;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((level_r != LVL_ZERO) && cts_sync_r) begin
                    pop_s     = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                busy_s  = 1'b1;
                // First half of each bit period low, second half high.
                fsclk_s = (div_r >= DIV_HALF);
                fsdi_s  = shift_r[0];
                if ((bit_r == BIT_LAST) && (div_r == DIV_LAST)) begin
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                busy_s = 1'b1;
                // The first hold-off cycle is the one whose pins go idle.
                done_s = (hold_r == HOLD_ZERO);
                if (hold_r == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: shift register, bit-period divider, bit and hold-off counters.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            shift_r <= {FRAME_W{1'b1}};
            div_r   <= DIV_ZERO;
            bit_r   <= BIT_ZERO;
            hold_r  <= HOLD_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r <= {head_s, 1'b0};
                        div_r   <= DIV_ZERO;
                        bit_r   <= BIT_ZERO;
                    end
                end
                ST_SHIFT: begin
                    hold_r <= HOLD_ZERO;
                    if (div_r == DIV_LAST) begin
                        div_r   <= DIV_ZERO;
                        bit_r   <= bit_r + BIT_ONE;
                        shift_r <= {1'b1, shift_r[FRAME_W-1:1]};
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                ST_HOLD: begin
                    hold_r <= hold_r + HOLD_ONE;
                end
                default: begin
                    hold_r <= HOLD_ZERO;
                end
            endcase
        end
    end

    // Registered pin and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            fsclk_r <= 1'b1;
            fsdi_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            fsclk_r <= fsclk_s;
            fsdi_r  <= fsdi_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

endmodule
